// File: rtl/branch_resolve_ctrl_if.sv
// Issue / resolve / redirect signal bundle between the branch resolve controller and its neighbours.
// The slave modport is the controller's view; the master modport drives it.
interface branch_resolve_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          i_issue_valid;
  logic          o_issue_ready;
  logic [31:0]   i_issue_pc;
  logic          i_pred_taken;
  logic [31:0]   i_pred_pc;
  logic          i_res_valid;
  logic          i_res_taken;
  logic [31:0]   i_res_dest_pc;
  logic          i_res_misalign;
  logic          o_redirect_valid;
  logic [31:0]   o_redirect_pc;
  logic          i_redirect_ack;
  logic          o_except_valid;
  logic [31:0]   o_except_pc;
  logic          o_flush;
  logic [CW-1:0] o_count;
  logic          o_err;

  modport slave (
    input  i_issue_valid, i_issue_pc, i_pred_taken, i_pred_pc,
    input  i_res_valid, i_res_taken, i_res_dest_pc, i_res_misalign,
    input  i_redirect_ack,
    output o_issue_ready, o_redirect_valid, o_redirect_pc,
    output o_except_valid, o_except_pc, o_flush, o_count, o_err
  );

  modport master (
    output i_issue_valid, i_issue_pc, i_pred_taken, i_pred_pc,
    output i_res_valid, i_res_taken, i_res_dest_pc, i_res_misalign,
    output i_redirect_ack,
    input  o_issue_ready, o_redirect_valid, o_redirect_pc,
    input  o_except_valid, o_except_pc, o_flush, o_count, o_err
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order branch resolution: queues predicted branches, checks each result against the oldest
// entry and sequences fetch redirect / misalign exception followed by a timed pipeline flush.
module branch_resolve_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  branch_resolve_ctrl_if.slave bus
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned FCW = $clog2(FLUSH_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  typedef struct packed {
    logic [31:0] issue_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } entry_t;

  entry_t          mem [DEPTH];

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            except_valid_q, except_valid_d;
  logic [31:0]     except_pc_q, except_pc_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;

  logic            issue_ready_c;
  logic            push;
  logic            do_pop;
  logic            do_clear;
  logic            mispredict;
  entry_t          head;
  entry_t          new_entry;

  assign issue_ready_c = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
  assign push          = bus.i_issue_valid & issue_ready_c;
  assign head          = mem[rd_ptr_q];
  assign mispredict    = (bus.i_res_taken != head.pred_taken) |
                         (bus.i_res_taken & (bus.i_res_dest_pc != head.pred_pc));

  assign new_entry.issue_pc   = bus.i_issue_pc;
  assign new_entry.pred_taken = bus.i_pred_taken;
  assign new_entry.pred_pc    = bus.i_pred_pc;

  // Next-state, queue bookkeeping and output next-values.
  always_comb begin
    state_d          = state_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    except_valid_d   = 1'b0;
    except_pc_d      = except_pc_q;
    err_d            = err_q;
    do_pop           = 1'b0;
    do_clear         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_res_valid) begin
          if (count_q == '0) begin
            err_d = 1'b1;
          end else if (bus.i_res_misalign) begin
            except_valid_d = 1'b1;
            except_pc_d    = head.issue_pc;
            do_clear       = 1'b1;
            flush_cnt_d    = FCW'(FLUSH_CYCLES - 1);
            state_d        = ST_FLUSH;
          end else if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.i_res_dest_pc;
            do_clear         = 1'b1;
            state_d          = ST_REDIRECT;
          end else begin
            do_pop = 1'b1;
          end
        end
      end
      ST_REDIRECT: begin
        if (bus.i_redirect_ack) begin
          redirect_valid_d = 1'b0;
          flush_cnt_d      = FCW'(FLUSH_CYCLES - 1);
          state_d          = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear also discards any branch pushed in the same cycle.
    if (do_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(do_pop);
    end

    flush_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      except_valid_q   <= 1'b0;
      except_pc_q      <= 32'h0;
      flush_q          <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      except_valid_q   <= except_valid_d;
      except_pc_q      <= except_pc_d;
      flush_q          <= flush_d;
      err_q            <= err_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= new_entry;
    end
  end

  assign bus.o_issue_ready    = issue_ready_c;
  assign bus.o_redirect_valid = redirect_valid_q;
  assign bus.o_redirect_pc    = redirect_pc_q;
  assign bus.o_except_valid   = except_valid_q;
  assign bus.o_except_pc      = except_pc_q;
  assign bus.o_flush          = flush_q;
  assign bus.o_count          = count_q;
  assign bus.o_err            = err_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus random traffic, every cycle compared
// against a queue-based behavioural model of the branch resolution rules.
module tb_branch_resolve_ctrl;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.DEPTH(DEPTH)) bus ();

  branch_resolve_ctrl #(
    .DEPTH       (DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ppc;
  } ent_t;

  // Behavioural model
  ent_t        q[$];
  bit          m_redir;
  logic [31:0] m_redir_pc;
  int          m_flush_left;
  bit          m_exc;
  logic [31:0] m_exc_pc;
  bit          m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic clear_inputs();
    bus.i_issue_valid  = 1'b0;
    bus.i_issue_pc     = 32'h0;
    bus.i_pred_taken   = 1'b0;
    bus.i_pred_pc      = 32'h0;
    bus.i_res_valid    = 1'b0;
    bus.i_res_taken    = 1'b0;
    bus.i_res_dest_pc  = 32'h0;
    bus.i_res_misalign = 1'b0;
    bus.i_redirect_ack = 1'b0;
  endtask

  // Apply the resolution rules to the current inputs for one clock.
  task automatic model_update();
    ent_t e;
    bit   idle;
    bit   can_push;
    bit   wrong;
    if (rst) begin
      q.delete();
      m_redir = 0; m_redir_pc = 32'h0; m_flush_left = 0;
      m_exc = 0; m_exc_pc = 32'h0; m_err = 0;
      return;
    end
    idle     = !m_redir && (m_flush_left == 0);
    can_push = idle && bus.i_issue_valid && (q.size() < DEPTH);
    e.pc = bus.i_issue_pc; e.pt = bus.i_pred_taken; e.ppc = bus.i_pred_pc;
    m_exc = 0;
    if (m_redir) begin
      if (bus.i_redirect_ack) begin
        m_redir      = 0;
        m_flush_left = FLUSH_CYCLES;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (bus.i_res_valid && q.size() == 0) begin
      m_err = 1;
      if (can_push) q.push_back(e);
    end else if (bus.i_res_valid) begin
      wrong = (bus.i_res_taken != q[0].pt) ||
              (bus.i_res_taken && bus.i_res_dest_pc != q[0].ppc);
      if (bus.i_res_misalign) begin
        m_exc = 1; m_exc_pc = q[0].pc;
        q.delete();
        m_flush_left = FLUSH_CYCLES;
      end else if (wrong) begin
        m_redir = 1; m_redir_pc = bus.i_res_dest_pc;
        q.delete();
      end else begin
        void'(q.pop_front());
        if (can_push) q.push_back(e);
      end
    end else if (can_push) begin
      q.push_back(e);
    end
  endtask

  task automatic compare_all();
    bit exp_ready;
    exp_ready = !m_redir && (m_flush_left == 0) && (q.size() < DEPTH);
    check("issue_ready", 32'(bus.o_issue_ready), 32'(exp_ready));
    check("count", 32'(bus.o_count), 32'(q.size()));
    check("redirect_valid", 32'(bus.o_redirect_valid), 32'(m_redir));
    if (m_redir) check("redirect_pc", bus.o_redirect_pc, m_redir_pc);
    check("flush", 32'(bus.o_flush), 32'(m_redir || (m_flush_left > 0)));
    check("except_valid", 32'(bus.o_except_valid), 32'(m_exc));
    if (m_exc) check("except_pc", bus.o_except_pc, m_exc_pc);
    check("err", 32'(bus.o_err), 32'(m_err));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_issue(input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_pc    = pc;
    bus.i_pred_taken  = pt;
    bus.i_pred_pc     = ppc;
  endtask

  task automatic drive_res(input logic taken, input logic [31:0] dest, input logic mis);
    bus.i_res_valid    = 1'b1;
    bus.i_res_taken    = taken;
    bus.i_res_dest_pc  = dest;
    bus.i_res_misalign = mis;
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 8 && (m_redir || m_flush_left > 0); i++) begin
      bus.i_redirect_ack = 1'b1;
      step();
      clear_inputs();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_redirect_pc", bus.o_redirect_pc, 32'h0);
    check("reset_except_pc", bus.o_except_pc, 32'h0);
    check("reset_ready", 32'(bus.o_issue_ready), 32'd1);

    // Correct not-taken prediction pops with no side effects
    drive_issue(32'h100, 1'b0, 32'h0); step(); clear_inputs();
    check("t1_count_after_issue", 32'(bus.o_count), 32'd1);
    drive_res(1'b0, 32'h104, 1'b0); step(); clear_inputs();
    check("t1_count_after_res", 32'(bus.o_count), 32'd0);
    check("t1_no_flush", 32'(bus.o_flush), 32'd0);

    // Taken with wrong target: redirect held until ack, then timed flush
    drive_issue(32'h1F0, 1'b1, 32'h200); step(); clear_inputs();
    drive_res(1'b1, 32'h204, 1'b0); step(); clear_inputs();
    check("t2_redirect_valid", 32'(bus.o_redirect_valid), 32'd1);
    check("t2_redirect_pc", bus.o_redirect_pc, 32'h204);
    step(); step();
    check("t2_redirect_held", 32'(bus.o_redirect_valid), 32'd1);
    bus.i_redirect_ack = 1'b1; step(); clear_inputs();
    check("t2_flush_1", 32'(bus.o_flush), 32'd1);
    step();
    check("t2_flush_2", 32'(bus.o_flush), 32'd1);
    step();
    check("t2_ready_after_flush", 32'(bus.o_issue_ready), 32'd1);
    check("t2_flush_done", 32'(bus.o_flush), 32'd0);

    // Fill the queue, drop an extra issue, then resolve+issue in one cycle
    for (int i = 0; i < 4; i++) begin
      drive_issue(32'h400 + 32'(i * 8), 1'b0, 32'h0); step(); clear_inputs();
    end
    check("t3_full_not_ready", 32'(bus.o_issue_ready), 32'd0);
    drive_issue(32'h500, 1'b0, 32'h0); step(); clear_inputs();
    check("t3_drop_count", 32'(bus.o_count), 32'd4);
    drive_res(1'b0, 32'h404, 1'b0); step(); clear_inputs();
    drive_res(1'b0, 32'h40C, 1'b0); drive_issue(32'h600, 1'b0, 32'h0); step(); clear_inputs();
    check("t3_push_pop_count", 32'(bus.o_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive_res(1'b0, 32'h0, 1'b0); step(); clear_inputs();
    end

    // Misaligned target on head with younger entries queued
    drive_issue(32'h300, 1'b1, 32'h302); step(); clear_inputs();
    drive_issue(32'h304, 1'b0, 32'h0); step(); clear_inputs();
    drive_issue(32'h308, 1'b0, 32'h0); step(); clear_inputs();
    drive_res(1'b1, 32'h302, 1'b1); step(); clear_inputs();
    check("t4_except_valid", 32'(bus.o_except_valid), 32'd1);
    check("t4_except_pc", bus.o_except_pc, 32'h300);
    check("t4_count", 32'(bus.o_count), 32'd0);
    check("t4_no_redirect", 32'(bus.o_redirect_valid), 32'd0);
    step();
    check("t4_except_pulse", 32'(bus.o_except_valid), 32'd0);
    run_until_idle();

    // Result with empty queue sets sticky error
    drive_res(1'b1, 32'h800, 1'b0); step(); clear_inputs();
    check("t5_err", 32'(bus.o_err), 32'd1);
    drive_issue(32'h700, 1'b0, 32'h0); step(); clear_inputs();
    check("t5_queue_ok", 32'(bus.o_count), 32'd1);
    drive_res(1'b0, 32'h704, 1'b0); step(); clear_inputs();
    check("t5_err_sticky", 32'(bus.o_err), 32'd1);

    // Reset in the middle of a redirect
    drive_issue(32'h900, 1'b0, 32'h0); step(); clear_inputs();
    drive_res(1'b1, 32'hA00, 1'b0); step(); clear_inputs();
    check("t6_in_redirect", 32'(bus.o_redirect_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_redirect_cleared", 32'(bus.o_redirect_valid), 32'd0);
    check("t6_redirect_pc", bus.o_redirect_pc, 32'h0);
    check("t6_flush", 32'(bus.o_flush), 32'd0);
    check("t6_err_cleared", 32'(bus.o_err), 32'd0);
    check("t6_count", 32'(bus.o_count), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_issue({$urandom_range(0, 255), 2'b00} | 32'h1000,
                    1'($urandom_range(0, 1)),
                    32'h2000 + 32'($urandom_range(0, 3) * 4));
      end
      if ($urandom_range(0, 2) != 0) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          drive_res(q[0].pt, q[0].pt ? q[0].ppc : q[0].pc + 32'd4, 1'b0);
        end else begin
          drive_res(1'($urandom_range(0, 1)),
                    32'h2000 + 32'($urandom_range(0, 3) * 4), 1'b0);
        end
        bus.i_res_misalign = ($urandom_range(0, 15) == 0);
      end
      bus.i_redirect_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    clear_inputs();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
